// File: rtl/d7s_scan_decoder_if.sv
// Pin-side and frame-side signals of the 7-segment scan decoder.
// The slave modport is the decoder; the master modport is whatever drives the pins and consumes frames.
// No handshake: pins are sampled continuously, frame outputs are pulses/levels.
interface d7s_scan_decoder_if;
  logic [2:0]  digit_en;
  logic [6:0]  seg;
  logic [11:0] digits;
  logic [2:0]  digit_bad;
  logic        frame_valid;
  logic        multi_err;
  logic        stale;

  modport master (
    output digit_en, seg,
    input  digits, digit_bad, frame_valid, multi_err, stale
  );

  modport slave (
    input  digit_en, seg,
    output digits, digit_bad, frame_valid, multi_err, stale
  );
endinterface

// File: rtl/d7s_scan_decoder.sv
// Recovers 3 digits from multiplexed 7-segment enable/segment pins and publishes complete frames.
// Latency: a stable pin change is captured on edge 2+STABLE_CYCLES after it is first sampled.
// No backpressure: frame_valid is a one-cycle pulse. Optional macro D7S_HEX_DECODE_EN adds A-F decode.
module d7s_scan_decoder #(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int EN_ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic rst,
  d7s_scan_decoder_if.slave bus
);

  localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [9:0]    INV_MASK    = {{3{EN_ACTIVE_LOW != 0}}, {7{SEG_ACTIVE_LOW != 0}}};

  // Returns {bad, value}; unknown patterns give value F with bad set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
`ifdef D7S_HEX_DECODE_EN
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
`endif
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [9:0]    sync1, sync2;
  logic [9:0]    samp, samp_prev;
  logic [2:0]    en;
  logic [6:0]    sg;
  logic [7:0]    cnt, cnt_nxt;
  logic          dwell;
  logic          samp_diff;
  logic          cap_evt, cap_one, cap_multi;
  logic          en_onehot;
  logic [4:0]    dec;
  logic [11:0]   stg_val, stg_val_nxt;
  logic [2:0]    stg_bad, stg_bad_nxt;
  logic [2:0]    seen, seen_nxt;
  logic          frame_done;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [11:0]   digits_q;
  logic [2:0]    digit_bad_q;
  logic          frame_valid_q, multi_err_q, stale_q;

  assign samp = sync2 ^ INV_MASK;
  assign en   = samp[9:7];
  assign sg   = samp[6:0];
  assign dec  = decode(sg);

  // Two-flop synchronizer on all pin inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.digit_en, bus.seg};
      sync2 <= sync1;
    end
  end

  // Stability tracking, capture decision, staging update and frame completion.
  always_comb begin
    samp_diff   = (samp != samp_prev);
    cnt_nxt     = cnt;
    en_onehot   = (en == 3'b001) || (en == 3'b010) || (en == 3'b100);
    stg_val_nxt = stg_val;
    stg_bad_nxt = stg_bad;
    seen_nxt    = seen;
    tcnt_nxt    = tcnt;

    if (samp_diff)                cnt_nxt = 8'd1;
    else if (cnt != STABLE_MAX)   cnt_nxt = cnt + 8'd1;

    // The dwell flag holds off repeat captures once cnt saturates.
    cap_evt   = !samp_diff && !dwell && (cnt_nxt == STABLE_MAX);
    cap_one   = cap_evt && en_onehot;
    cap_multi = cap_evt && !en_onehot && (en != 3'b000);

    for (int i = 0; i < 3; i++) begin
      if (cap_one && en[i]) begin
        stg_val_nxt[i*4 +: 4] = dec[3:0];
        stg_bad_nxt[i]        = dec[4];
      end
    end
    if (cap_one) seen_nxt = seen | en;
    frame_done = cap_one && (seen_nxt == 3'b111);

    if (cap_one)                  tcnt_nxt = '0;
    else if (tcnt != TIMEOUT_MAX) tcnt_nxt = tcnt + TW'(1);
  end

  // Stability counter, previous sample and once-per-dwell flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_prev <= '0;
      cnt       <= '0;
      dwell     <= 1'b0;
    end else begin
      samp_prev <= samp;
      cnt       <= cnt_nxt;
      if (samp_diff)    dwell <= 1'b0;
      else if (cap_evt) dwell <= 1'b1;
    end
  end

  // Staging registers, seen mask and published frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_val       <= '0;
      stg_bad       <= '0;
      seen          <= '0;
      digits_q      <= '0;
      digit_bad_q   <= '0;
      frame_valid_q <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      stg_val       <= stg_val_nxt;
      stg_bad       <= stg_bad_nxt;
      seen          <= frame_done ? 3'b000 : seen_nxt;
      frame_valid_q <= frame_done;
      multi_err_q   <= cap_multi;
      if (frame_done) begin
        digits_q    <= stg_val_nxt;
        digit_bad_q <= stg_bad_nxt;
      end
    end
  end

  // Capture watchdog; stale tracks the saturated counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      stale_q <= 1'b0;
    end else begin
      tcnt    <= tcnt_nxt;
      stale_q <= (tcnt_nxt == TIMEOUT_MAX);
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_bad   = digit_bad_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.multi_err   = multi_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// Directed bench for d7s_scan_decoder: frames, glitches, overwrite, errors, timeout and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_d7s_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;
  int   me_cnt = 0;

  d7s_scan_decoder_if bus ();

  d7s_scan_decoder #(
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(50),
    .SEG_ACTIVE_LOW(0),
    .EN_ACTIVE_LOW (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters used by the scenarios.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_cnt++;
    if (bus.multi_err === 1'b1)   me_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.digit_en = 3'b000;
    bus.seg = 7'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply a pin pattern at the current falling edge and hold it for n cycles.
  task automatic drive(input logic [2:0] en, input logic [6:0] sg, input int n);
    bus.digit_en = en;
    bus.seg = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.digit_en = 3'b000;
    bus.seg = 7'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.digits !== 12'h000) begin errors++; $display("FAIL reset_digits got=%h want=000", bus.digits); end
    checks++; if (bus.digit_bad !== 3'b000) begin errors++; $display("FAIL reset_bad got=%b want=000", bus.digit_bad); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b want=0", bus.frame_valid); end
    checks++; if (bus.multi_err !== 1'b0) begin errors++; $display("FAIL reset_me got=%b want=0", bus.multi_err); end
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL reset_stale got=%b want=0", bus.stale); end
    rst = 1'b0;
  endtask

  task automatic test_clean_frame();
    int base;
    do_reset();
    base = fv_cnt;
    drive(3'b001, 7'h4F, 20);
    drive(3'b010, 7'h6D, 20);
    drive(3'b100, 7'h07, 20);
    drive(3'b000, 7'h00, 5);
    checks++; if (fv_cnt - base !== 1) begin errors++; $display("FAIL clean_fv_count got=%0d want=1", fv_cnt - base); end
    checks++; if (bus.digits !== 12'h753) begin errors++; $display("FAIL clean_digits got=%h want=753", bus.digits); end
    checks++; if (bus.digit_bad !== 3'b000) begin errors++; $display("FAIL clean_bad got=%b want=000", bus.digit_bad); end
  endtask

  task automatic test_glitch();
    int base;
    int cap_k;
    do_reset();
    drive(3'b100, 7'h3F, 20);
    drive(3'b010, 7'h06, 20);
    base = fv_cnt;
    for (int c = 0; c < 10; c++) drive(3'b001, (c % 2 == 0) ? 7'h5B : 7'h06, 3);
    checks++; if (fv_cnt - base !== 0) begin errors++; $display("FAIL glitch_no_capture got=%0d want=0", fv_cnt - base); end
    bus.seg = 7'h5B;
    cap_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1 && cap_k == 0) cap_k = k;
    end
    checks++; if (cap_k !== 10) begin errors++; $display("FAIL glitch_latency got=%0d want=10", cap_k); end
    checks++; if (bus.digits !== 12'h012) begin errors++; $display("FAIL glitch_digits got=%h want=012", bus.digits); end
    checks++; if (fv_cnt - base !== 1) begin errors++; $display("FAIL glitch_fv_count got=%0d want=1", fv_cnt - base); end
  endtask

  task automatic test_overwrite_blank();
    int base;
    do_reset();
    base = fv_cnt;
    drive(3'b001, 7'h3F, 20);
    drive(3'b000, 7'h3F, 10);
    drive(3'b001, 7'h7F, 20);
    drive(3'b010, 7'h66, 20);
    checks++; if (fv_cnt - base !== 0) begin errors++; $display("FAIL ovw_early_frame got=%0d want=0", fv_cnt - base); end
    drive(3'b100, 7'h6F, 20);
    drive(3'b000, 7'h00, 5);
    checks++; if (fv_cnt - base !== 1) begin errors++; $display("FAIL ovw_fv_count got=%0d want=1", fv_cnt - base); end
    checks++; if (bus.digits !== 12'h948) begin errors++; $display("FAIL ovw_digits got=%h want=948", bus.digits); end
    checks++; if (bus.digit_bad !== 3'b000) begin errors++; $display("FAIL ovw_bad got=%b want=000", bus.digit_bad); end
  endtask

  task automatic test_multi_err();
    int fbase;
    int mbase;
    do_reset();
    fbase = fv_cnt;
    mbase = me_cnt;
    drive(3'b001, 7'h06, 20);
    drive(3'b011, 7'h5B, 20);
    checks++; if (me_cnt - mbase !== 1) begin errors++; $display("FAIL multi_pulse got=%0d want=1", me_cnt - mbase); end
    drive(3'b010, 7'h4F, 20);
    checks++; if (fv_cnt - fbase !== 0) begin errors++; $display("FAIL multi_seen_kept got=%0d want=0", fv_cnt - fbase); end
    drive(3'b100, 7'h66, 20);
    drive(3'b000, 7'h00, 5);
    checks++; if (fv_cnt - fbase !== 1) begin errors++; $display("FAIL multi_fv_count got=%0d want=1", fv_cnt - fbase); end
    checks++; if (bus.digits !== 12'h431) begin errors++; $display("FAIL multi_digits got=%h want=431", bus.digits); end
  endtask

  task automatic test_bad_pattern();
    logic [11:0] exp_d;
    logic [2:0]  exp_b;
`ifdef D7S_HEX_DECODE_EN
    exp_d = 12'h1A0;
    exp_b = 3'b000;
`else
    exp_d = 12'h1F0;
    exp_b = 3'b010;
`endif
    do_reset();
    drive(3'b001, 7'h3F, 20);
    drive(3'b010, 7'h77, 20);
    drive(3'b100, 7'h06, 20);
    drive(3'b000, 7'h00, 5);
    checks++; if (bus.digits !== exp_d) begin errors++; $display("FAIL bad_digits got=%h want=%h", bus.digits, exp_d); end
    checks++; if (bus.digit_bad !== exp_b) begin errors++; $display("FAIL bad_flags got=%b want=%b", bus.digit_bad, exp_b); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (49) @(negedge clk);
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_early got=%b want=0", bus.stale); end
    @(negedge clk);
    checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_at_50 got=%b want=1", bus.stale); end
    drive(3'b001, 7'h06, 9);
    checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_before_cap got=%b want=1", bus.stale); end
    @(negedge clk);
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_cleared got=%b want=0", bus.stale); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    drive(3'b001, 7'h3F, 20);
    drive(3'b010, 7'h06, 20);
    drive(3'b100, 7'h5B, 20);
    checks++; if (bus.digits !== 12'h210) begin errors++; $display("FAIL mid_pre_digits got=%h want=210", bus.digits); end
    drive(3'b001, 7'h66, 20);
    drive(3'b010, 7'h6D, 20);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.digits !== 12'h000) begin errors++; $display("FAIL mid_rst_digits got=%h want=000", bus.digits); end
    checks++; if (bus.digit_bad !== 3'b000) begin errors++; $display("FAIL mid_rst_bad got=%b want=000", bus.digit_bad); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_fv got=%b want=0", bus.frame_valid); end
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL mid_rst_stale got=%b want=0", bus.stale); end
    @(negedge clk);
    rst = 1'b0;
    base = fv_cnt;
    drive(3'b100, 7'h7F, 20);
    checks++; if (fv_cnt - base !== 0) begin errors++; $display("FAIL mid_partial_frame got=%0d want=0", fv_cnt - base); end
    drive(3'b001, 7'h07, 20);
    drive(3'b010, 7'h4F, 20);
    drive(3'b000, 7'h00, 5);
    checks++; if (fv_cnt - base !== 1) begin errors++; $display("FAIL mid_fv_count got=%0d want=1", fv_cnt - base); end
    checks++; if (bus.digits !== 12'h837) begin errors++; $display("FAIL mid_digits got=%h want=837", bus.digits); end
  endtask

  initial begin
    bus.digit_en = 3'b000;
    bus.seg = 7'h00;
    test_reset();
    test_clean_frame();
    test_glitch();
    test_overwrite_blank();
    test_multi_err();
    test_bad_pattern();
    test_timeout();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/d7s_scan_decoder.md
Name: d7s_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver: samples the 3 digit-enable (transistor) lines and the 7 segment lines, and recovers the displayed digits.
- Each stable segment pattern is decoded back to a 4-bit value for the active digit, and a complete 3-digit frame is published.
- Used for on-chip loopback self-check of the display path and as a capture block for external multiplexed displays.
- Pure synchronous design in the clk domain; all pin inputs are treated as asynchronous.

Parameters:
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before a digit is captured; legal range 2..255.
- TIMEOUT_CYCLES, 1000000: cycles without any capture before `stale` asserts; counter width is $clog2(TIMEOUT_CYCLES+1).
- SEG_ACTIVE_LOW, 0: 1 inverts `seg` after synchronization, before compare and decode.
- EN_ACTIVE_LOW, 0: 1 inverts `digit_en` after synchronization.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- digit_en  in  3  digit select lines; bit i selects digit i, bit 0 is least significant
- seg  in  7  segment lines; seg[0]=a, seg[1]=b, ... seg[6]=g
- digits  out  12  last complete frame, {d2,d1,d0}, 4 bits each
- digit_bad  out  3  per-digit flag in the last frame: pattern did not decode
- frame_valid  out  1  one-cycle pulse when `digits`/`digit_bad` update
- multi_err  out  1  one-cycle pulse: more than one enable active and stable
- stale  out  1  no capture for TIMEOUT_CYCLES cycles

Behaviour:
- Reset: all outputs 0; synchronizers, stability counter, captured-this-dwell flag, seen mask, staging registers and timeout counter all 0.
- Input sync: 2-flop synchronizer on all 10 input bits. Polarity inversion is applied after the second flop, giving sample S = {en, sg}.
- Stability counter:
  - If S differs from the previous S, cnt <= 1 and the dwell flag is cleared.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Capture event: occurs on the cycle cnt reaches STABLE_CYCLES, once per dwell (dwell flag set).
  - en all-zero: blanking; no capture, no error.
  - en one-hot with index i: staging[i] <= decode(sg), bad[i] <= invalid, seen[i] <= 1, timeout counter cleared.
  - en with ≥2 bits set: `multi_err` pulses for 1 cycle; nothing stored.
- Decode (sg hex → value): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Any other pattern → value 4'hF with bad=1.
- Frame completion:
  - When a capture makes seen==3'b111, `digits` and `digit_bad` load the staging values, including that capture.
  - `frame_valid` pulses on the same edge, and `seen` clears to 0.
- Same digit captured twice before frame completion: the later value overwrites the staging register; `seen` is unchanged.
- Latency: a pin change held stable reaches staging/outputs on clock edge 2+STABLE_CYCLES after the first edge sampling it.
- Timeout:
  - Counter increments each cycle without a capture, saturating at TIMEOUT_CYCLES.
  - `stale` = (counter == TIMEOUT_CYCLES); it is registered and drops on the cycle after the next capture.
- Async reset mid-frame discards the partial frame; outputs return to 0 immediately.

Optional Feature:
- Macro: D7S_HEX_DECODE_EN.
- Defined: additional patterns decode as 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F with bad=0.
  - 4'hF from pattern 71 is valid; 4'hF with bad=1 still marks an invalid pattern.
- Undefined: those patterns are invalid (value F, bad=1); decode logic is the 10-entry table only.

Test Plan:
- Clean frame: drive en=001/seg=4F, then 010/6D, then 100/07, each 20 cycles with STABLE_CYCLES=8 → one `frame_valid` pulse, digits=12'h753, digit_bad=000.
- Glitch rejection: en=001, seg toggles 06↔5B every 3 cycles for 30 cycles, then holds 5B → single capture of 2 into d0, exactly 8+2 edges after the hold starts.
- Overwrite and blanking: en=001/seg=3F, blank 000 for 10 cycles, en=001/seg=7F, then digits 1 and 2 with 66/6F → digits=12'h948; no capture during blanking.
- Errors:
  - en=011 held 20 cycles → `multi_err` pulses once, seen unchanged.
  - seg=77 on digit 1 without macro → digit_bad=010, d1=F.
  - With D7S_HEX_DECODE_EN → d1=A, bad=0.
- Timeout/reset: TIMEOUT_CYCLES=50, no input → `stale`=1 at cycle 50; a capture clears it. Assert rst after 2 digits captured → all outputs 0 asynchronously, and the next frame needs all 3 digits again.
